// File: rtl/framebuffer_scanout_pkg.sv
// Shared definitions for the framebuffer scanout block: display modes, default geometry
// and the fixed colour-bar table.
package framebuffer_scanout_pkg;

    typedef enum logic [1:0] {
        ModeFb    = 2'd0,
        ModeBars  = 2'd1,
        ModeSolid = 2'd2,
        ModeRsvd  = 2'd3
    } modeT;

    localparam int unsigned FB_DEPTH = 307200;
    localparam int unsigned NUM_BARS = 8;
    localparam int unsigned NUM_PAL  = 16;

    // Bar 0 is the leftmost bar on screen.
    localparam logic [11:0] BAR_COLORS [NUM_BARS] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    function automatic logic [11:0] greyLevel(input logic [3:0] idx);
        return {idx, idx, idx};
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port and one synchronous read port with
// one cycle of read latency. Contents are deliberately not reset so it maps onto block RAM.
module fb_ram #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned PIX_W  = 4,
    parameter int unsigned DEPTH  = 307200
) (
    input  logic              iClk,
    input  logic              iWe,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [PIX_W-1:0]  iWrData,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic [PIX_W-1:0]  oRdData
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (iWe) begin
            mem[iWrAddr] <= iWrData;
        end
    end

    always_ff @(posedge iClk) begin
        oRdData <= mem[iRdAddr];
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Two-stage pixel pipeline: framebuffer read, then palette / colour-bar lookup, with the
// beam syncs delayed to stay aligned with the pixel colour.
module framebuffer_scanout #(
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned PIX_W    = 4,
    parameter int unsigned FB_DEPTH = framebuffer_scanout_pkg::FB_DEPTH,
    parameter int unsigned BAR_W    = 80
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iDE,
    input  logic              iHS,
    input  logic              iVS,
    input  logic [ADDR_W-1:0] iPos,
    input  logic              iWrValid,
    output logic              oWrReady,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [PIX_W-1:0]  iWrData,
    input  logic              iPalWe,
    input  logic [3:0]        iPalIdx,
    input  logic [11:0]       iPalColor,
    input  logic [1:0]        iMode,
    output logic              oDE,
    output logic              oHS,
    output logic              oVS,
    output logic [11:0]       oRGB
);

    import framebuffer_scanout_pkg::*;

    // One extra bit so a depth of exactly 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DepthLimit = (ADDR_W + 1)'(FB_DEPTH);

    logic             wrEn;
    logic             posInRange;
    logic [PIX_W-1:0] ramData;
    logic [3:0]       ramIdx;

    logic [9:0]       colQ;
    logic             vsPrevQ;
    modeT             modeQ;
    logic [11:0]      palQ [NUM_PAL];

    logic             de1Q;
    logic             hs1Q;
    logic             vs1Q;
    logic             inRange1Q;
    logic [9:0]       col1Q;

    logic [9:0]       barWide;
    logic [2:0]       barIdx;
    logic [11:0]      pixColor;

    // Host writes only land during blanking; out-of-range addresses are acked and dropped.
    assign oWrReady   = ~iDE;
    assign wrEn       = iWrValid && oWrReady && ({1'b0, iWrAddr} < DepthLimit);
    assign posInRange = {1'b0, iPos} < DepthLimit;

    fb_ram #(
        .ADDR_W (ADDR_W),
        .PIX_W  (PIX_W),
        .DEPTH  (FB_DEPTH)
    ) uFbRam (
        .iClk    (iClk),
        .iWe     (wrEn),
        .iWrAddr (iWrAddr),
        .iWrData (iWrData),
        .iRdAddr (iPos),
        .oRdData (ramData)
    );

    assign ramIdx = 4'(ramData);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            colQ <= 10'd0;
        end else if (iDE) begin
            colQ <= colQ + 10'd1;
        end else begin
            colQ <= 10'd0;
        end
    end

    // The mode only changes at a frame boundary so a frame is never drawn in two modes.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            vsPrevQ <= 1'b1;
            modeQ   <= ModeFb;
        end else begin
            vsPrevQ <= iVS;
            if (vsPrevQ && !iVS) begin
                modeQ <= modeT'(iMode);
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < int'(NUM_PAL); i++) begin
                palQ[i] <= greyLevel(4'(i));
            end
        end else if (iPalWe) begin
            palQ[iPalIdx] <= iPalColor;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            de1Q      <= 1'b0;
            hs1Q      <= 1'b1;
            vs1Q      <= 1'b1;
            inRange1Q <= 1'b0;
            col1Q     <= 10'd0;
        end else begin
            de1Q      <= iDE;
            hs1Q      <= iHS;
            vs1Q      <= iVS;
            inRange1Q <= posInRange;
            col1Q     <= colQ;
        end
    end

    always_comb begin
        barWide  = col1Q / 10'(BAR_W);
        barIdx   = (barWide > 10'd7) ? 3'd7 : barWide[2:0];
        pixColor = 12'h000;
        if (de1Q && inRange1Q) begin
            unique case (modeQ)
                ModeBars:  pixColor = BAR_COLORS[barIdx];
                ModeSolid: pixColor = palQ[0];
                default:   pixColor = palQ[ramIdx];
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oDE  <= 1'b0;
            oHS  <= 1'b1;
            oVS  <= 1'b1;
            oRGB <= 12'h000;
        end else begin
            oDE  <= de1Q;
            oHS  <= hs1Q;
            oVS  <= vs1Q;
            oRGB <= pixColor;
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Randomised bench: a frame-level reference model predicts every output cycle into a
// scoreboard queue that an independent monitor drains two clocks later.
module tb_framebuffer_scanout;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned PIX_W  = 4;
    localparam int unsigned DEPTH  = 307200;
    localparam int unsigned BAR_W  = 80;
    localparam int unsigned FILL   = 64;

    logic              iClk      = 1'b0;
    logic              iRst      = 1'b0;
    logic              iDE       = 1'b0;
    logic              iHS       = 1'b1;
    logic              iVS       = 1'b1;
    logic [ADDR_W-1:0] iPos      = '0;
    logic              iWrValid  = 1'b0;
    logic [ADDR_W-1:0] iWrAddr   = '0;
    logic [PIX_W-1:0]  iWrData   = '0;
    logic              iPalWe    = 1'b0;
    logic [3:0]        iPalIdx   = '0;
    logic [11:0]       iPalColor = '0;
    logic [1:0]        iMode     = '0;
    logic              oWrReady;
    logic              oDE;
    logic              oHS;
    logic              oVS;
    logic [11:0]       oRGB;

    framebuffer_scanout #(
        .ADDR_W   (ADDR_W),
        .PIX_W    (PIX_W),
        .FB_DEPTH (DEPTH),
        .BAR_W    (BAR_W)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iDE       (iDE),
        .iHS       (iHS),
        .iVS       (iVS),
        .iPos      (iPos),
        .iWrValid  (iWrValid),
        .oWrReady  (oWrReady),
        .iWrAddr   (iWrAddr),
        .iWrData   (iWrData),
        .iPalWe    (iPalWe),
        .iPalIdx   (iPalIdx),
        .iPalColor (iPalColor),
        .iMode     (iMode),
        .oDE       (oDE),
        .oHS       (oHS),
        .oVS       (oVS),
        .oRGB      (oRGB)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic              de;
        logic              hs;
        logic              vs;
        logic [ADDR_W-1:0] pos;
        logic              wrValid;
        logic [ADDR_W-1:0] wrAddr;
        logic [PIX_W-1:0]  wrData;
        logic              palWe;
        logic [3:0]        palIdx;
        logic [11:0]       palColor;
        logic [1:0]        mode;
    } stimT;

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        int          due;
        string       tag;
    } expT;

    expT         sbQ[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    string       curTag = "idle";
    logic [1:0]  curMode = 2'd0;

    // Reference model state
    logic [11:0] barTab [8];
    logic [11:0] palM [16];
    logic [3:0]  fbM [FILL];
    int          modeM   = 0;
    bit          vsPrevM = 1'b1;
    int          colM    = 0;

    task automatic checkVal(input string name, input logic [11:0] got, input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic stimT idle();
        stimT s;
        s.de = 1'b0; s.hs = 1'b1; s.vs = 1'b1; s.pos = '0;
        s.wrValid = 1'b0; s.wrAddr = '0; s.wrData = '0;
        s.palWe = 1'b0; s.palIdx = '0; s.palColor = '0;
        s.mode = curMode;
        return s;
    endfunction

    // Drive one cycle of inputs and predict the output it produces two clocks later.
    task automatic apply(input stimT s);
        expT e;
        int  col;
        int  bar;
        iDE = s.de; iHS = s.hs; iVS = s.vs; iPos = s.pos;
        iWrValid = s.wrValid; iWrAddr = s.wrAddr; iWrData = s.wrData;
        iPalWe = s.palWe; iPalIdx = s.palIdx; iPalColor = s.palColor; iMode = s.mode;
        #1;
        checkVal("wr_ready", 12'(oWrReady), 12'(!s.de));
        if (vsPrevM && !s.vs) modeM = int'(s.mode);
        vsPrevM = s.vs;
        if (s.palWe) palM[s.palIdx] = s.palColor;
        col  = colM;
        colM = s.de ? colM + 1 : 0;
        e.de = s.de; e.hs = s.hs; e.vs = s.vs; e.due = cyc + 2; e.tag = curTag;
        if (!s.de || 32'(s.pos) >= DEPTH) begin
            e.rgb = 12'h000;
        end else begin
            case (modeM)
                1: begin
                    bar = col / int'(BAR_W);
                    if (bar > 7) bar = 7;
                    e.rgb = barTab[bar];
                end
                2:       e.rgb = palM[0];
                default: e.rgb = palM[fbM[s.pos[5:0]]];
            endcase
        end
        if (s.wrValid && !s.de && 32'(s.wrAddr) < DEPTH) fbM[s.wrAddr[5:0]] = s.wrData;
        sbQ.push_back(e);
    endtask

    task automatic step(input stimT s);
        @(negedge iClk);
        apply(s);
    endtask

    task automatic pulseReset(input int hold);
        expT e;
        @(negedge iClk);
        iRst = 1'b1;
        sbQ.delete();
        #1;
        checkVal("rst_de", 12'(oDE), 12'h000);
        checkVal("rst_hs", 12'(oHS), 12'h001);
        checkVal("rst_vs", 12'(oVS), 12'h001);
        checkVal("rst_rgb", oRGB, 12'h000);
        for (int i = 0; i < 16; i++) palM[i] = {4'(i), 4'(i), 4'(i)};
        modeM = 0; vsPrevM = 1'b1; colM = 0;
        repeat (hold) @(posedge iClk);
        @(negedge iClk);
        checkVal("rst_hold_de", 12'(oDE), 12'h000);
        checkVal("rst_hold_rgb", oRGB, 12'h000);
        iRst = 1'b0;
        e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'h000; e.due = cyc + 1;
        e.tag = "post_rst";
        sbQ.push_back(e);
        apply(idle());
    endtask

    task automatic blank(input bit rnd);
        stimT s;
        for (int i = 0; i < 12; i++) begin
            s = idle();
            s.hs = (i >= 2 && i < 6) ? 1'b0 : 1'b1;
            if (rnd && $urandom_range(0, 2) == 0) begin
                s.wrValid = 1'b1;
                s.wrAddr = ($urandom_range(0, 7) == 0) ? ADDR_W'(DEPTH + $urandom_range(0, 500))
                                                      : ADDR_W'($urandom_range(0, FILL - 1));
                s.wrData = 4'($urandom);
            end
            if (rnd && $urandom_range(0, 4) == 0) begin
                s.palWe = 1'b1; s.palIdx = 4'($urandom); s.palColor = 12'($urandom);
            end
            step(s);
        end
    endtask

    task automatic runLine(input int nPix, input bit seqPos, input bit rnd);
        stimT s;
        blank(rnd);
        for (int i = 0; i < nPix; i++) begin
            s = idle();
            s.de = 1'b1;
            if (seqPos) s.pos = ADDR_W'(i % int'(FILL));
            else if (rnd && $urandom_range(0, 15) == 0) s.pos = ADDR_W'(DEPTH + $urandom_range(0, 1000));
            else s.pos = ADDR_W'($urandom_range(0, FILL - 1));
            if (rnd && $urandom_range(0, 9) == 0) begin
                s.wrValid = 1'b1; s.wrAddr = ADDR_W'($urandom_range(0, FILL - 1));
                s.wrData = 4'($urandom);
            end
            if (rnd && $urandom_range(0, 19) == 0) begin
                s.palWe = 1'b1; s.palIdx = 4'($urandom); s.palColor = 12'($urandom);
            end
            step(s);
        end
    endtask

    task automatic vsync();
        stimT s;
        for (int i = 0; i < 6; i++) begin
            s = idle();
            s.vs = (i >= 1 && i < 4) ? 1'b0 : 1'b1;
            step(s);
        end
    endtask

    always @(posedge iClk) begin : monitor
        expT e;
        cyc = cyc + 1;
        #1;
        if (!iRst) begin
            while (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
                e = sbQ.pop_front();
                total++;
                if (e.due != cyc) begin
                    bad++;
                    $display("FAIL %s stale: due=%0d now=%0d", e.tag, e.due, cyc);
                end else if ({oDE, oHS, oVS, oRGB} !== {e.de, e.hs, e.vs, e.rgb}) begin
                    bad++;
                    $display("FAIL %s @%0d: got de=%b hs=%b vs=%b rgb=%h want de=%b hs=%b vs=%b rgb=%h",
                             e.tag, cyc, oDE, oHS, oVS, oRGB, e.de, e.hs, e.vs, e.rgb);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        stimT s;
        barTab = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        pulseReset(2);

        curTag = "de_latency";
        repeat (4) begin
            s = idle(); s.de = 1'b1; s.hs = 1'b0; s.pos = ADDR_W'(DEPTH);
            step(s);
        end

        curTag = "fill";
        for (int a = 0; a < int'(FILL); a++) begin
            s = idle(); s.wrValid = 1'b1; s.wrAddr = ADDR_W'(a); s.wrData = 4'($urandom);
            step(s);
        end
        curTag = "oob_write";
        s = idle(); s.wrValid = 1'b1; s.wrAddr = ADDR_W'(DEPTH); s.wrData = 4'hF;
        step(s);

        curTag = "fb_addr5";
        s = idle(); s.wrValid = 1'b1; s.wrAddr = ADDR_W'(5); s.wrData = 4'd3;
        step(s);
        s = idle(); s.palWe = 1'b1; s.palIdx = 4'd3; s.palColor = 12'hA5C;
        step(s);
        s = idle(); s.de = 1'b1; s.pos = ADDR_W'(5);
        step(s);

        curTag = "write_in_de";
        s = idle(); s.de = 1'b1; s.pos = ADDR_W'(7);
        s.wrValid = 1'b1; s.wrAddr = ADDR_W'(7); s.wrData = ~fbM[7];
        step(s);
        s = idle(); s.de = 1'b1; s.pos = ADDR_W'(7);
        step(s);

        curTag = "mode_mid_frame";
        runLine(60, 1'b0, 1'b1);
        curMode = 2'd1;
        runLine(60, 1'b0, 1'b1);
        vsync();
        curTag = "bars";
        runLine(640, 1'b1, 1'b0);
        runLine(100, 1'b0, 1'b1);

        curTag = "pal_same_cycle";
        curMode = 2'd2;
        vsync();
        blank(1'b0);
        for (int i = 0; i < 10; i++) begin
            s = idle(); s.de = 1'b1; s.pos = ADDR_W'(i);
            if (i == 5) begin
                s.palWe = 1'b1; s.palIdx = 4'd0; s.palColor = 12'h123;
            end
            step(s);
        end

        curTag = "mode3";
        curMode = 2'd3;
        vsync();
        runLine(80, 1'b0, 1'b1);

        curTag = "mid_line_rst";
        curMode = 2'd0;
        vsync();
        runLine(30, 1'b0, 1'b1);
        pulseReset(1);
        curTag = "grey_after_rst";
        runLine(64, 1'b1, 1'b0);

        curTag = "random";
        for (int f = 0; f < 4; f++) begin
            curMode = 2'($urandom_range(0, 3));
            vsync();
            for (int l = 0; l < 3; l++) begin
                runLine(int'($urandom_range(40, 120)), 1'b0, 1'b1);
                if ($urandom_range(0, 1) == 0) curMode = 2'($urandom_range(0, 3));
            end
        end

        curTag = "drain";
        repeat (4) step(idle());
        repeat (3) @(posedge iClk);
        #2;
        checkVal("scoreboard_empty", 12'(sbQ.size()), 12'h000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
